// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank responder.
// Exposes REGISTER_COUNT registers of DATA_WIDTH bits at BASE_ADDRESS. AW and W are
// captured independently; the edge that captures the second of the two commits the write.
// Reads sample the register contents as they were before the AR handshake edge.
// Optional build macro: AXI4_LITE_SLAVE_OOR_ERROR_EN -- out-of-range accesses answer SLVERR
// instead of OKAY (data is never written and reads return zero in either build).
module axi4_lite_slave_regs #(
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter int unsigned                ADDRESS_WIDTH  = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS   = 32'h4000_0000,
  parameter int unsigned                REGISTER_COUNT = 8
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  // Write address channel
  input  logic [ADDRESS_WIDTH-1:0]             s_axi_awaddr,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]                s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]              s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  // Write response channel
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  // Read address channel
  input  logic [ADDRESS_WIDTH-1:0]             s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  // Read data channel
  output logic [DATA_WIDTH-1:0]                s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  // Fabric side
  output logic [REGISTER_COUNT*DATA_WIDTH-1:0] register_file,
  output logic [REGISTER_COUNT-1:0]            register_write_pulse
);

  localparam int unsigned StrbW     = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb   = $clog2(StrbW);
  localparam int unsigned IdxW      = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1;
  localparam int unsigned SpanBytes = REGISTER_COUNT * StrbW;
  localparam logic [ADDRESS_WIDTH-1:0] Span = ADDRESS_WIDTH'(SpanBytes);

  localparam logic [1:0] RespOkay = 2'b00;
`ifdef AXI4_LITE_SLAVE_OOR_ERROR_EN
  localparam logic [1:0] RespOor  = 2'b10;
`else
  localparam logic [1:0] RespOor  = 2'b00;
`endif

  // Address decode; BASE_ADDRESS is aligned to the bank span, so the byte offset bits simply
  // drop out of the index and unaligned addresses hit the containing word.
  function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] off;
    off = addr - BASE_ADDRESS;
    return (addr >= BASE_ADDRESS) && (off < Span);
  endfunction

  function automatic logic [IdxW-1:0] addr_index(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] off;
    off = (addr - BASE_ADDRESS) >> AddrLsb;
    return off[IdxW-1:0];
  endfunction

  typedef enum logic [1:0] {WIdle, WHaveAddr, WHaveData, WResp} wstate_e;
  typedef enum logic [0:0] {RIdle, RResp} rstate_e;

  // Register bank
  logic [DATA_WIDTH-1:0] regs_q [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_COUNT];

  // Write path state
  wstate_e                    wstate_q, wstate_d;
  logic [ADDRESS_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [StrbW-1:0]           wstrb_q, wstrb_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [REGISTER_COUNT-1:0]  pulse_q, pulse_d;

  // Read path state
  rstate_e                    rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;

  logic                       aw_hs, w_hs, ar_hs;
  logic                       commit;
  logic [ADDRESS_WIDTH-1:0]   cm_addr;
  logic [DATA_WIDTH-1:0]      cm_data;
  logic [StrbW-1:0]           cm_strb;
  logic                       cm_in_range;
  logic [IdxW-1:0]            cm_idx;
  logic                       ar_in_range;
  logic [IdxW-1:0]            ar_idx;

  // Ready signals are gated by resetn so nothing handshakes while reset is held.
  assign s_axi_awready = resetn && ((wstate_q == WIdle) || (wstate_q == WHaveData));
  assign s_axi_wready  = resetn && ((wstate_q == WIdle) || (wstate_q == WHaveAddr));
  assign s_axi_arready = resetn && (rstate_q == RIdle);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit operands: a held half comes from its capture register, the other from the bus.
  assign cm_addr     = (wstate_q == WHaveAddr) ? awaddr_q : s_axi_awaddr;
  assign cm_data     = (wstate_q == WHaveData) ? wdata_q  : s_axi_wdata;
  assign cm_strb     = (wstate_q == WHaveData) ? wstrb_q  : s_axi_wstrb;
  assign cm_in_range = addr_in_range(cm_addr);
  assign cm_idx      = addr_index(cm_addr);

  assign ar_in_range = addr_in_range(s_axi_araddr);
  assign ar_idx      = addr_index(s_axi_araddr);

  // Write FSM next state, capture of the first half, and bytewise register update on commit.
  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    pulse_d  = '0;
    regs_d   = regs_q;
    commit   = 1'b0;

    unique case (wstate_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d = s_axi_awaddr;
          wstate_d = WHaveAddr;
        end else if (w_hs) begin
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          wstate_d = WHaveData;
        end
      end
      WHaveAddr: begin
        if (w_hs) commit = 1'b1;
      end
      WHaveData: begin
        if (aw_hs) commit = 1'b1;
      end
      WResp: begin
        if (s_axi_bready) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase

    if (commit) begin
      wstate_d = WResp;
      if (cm_in_range) begin
        bresp_d         = RespOkay;
        pulse_d[cm_idx] = 1'b1;
        for (int k = 0; k < StrbW; k++) begin
          if (cm_strb[k]) regs_d[cm_idx][8*k +: 8] = cm_data[8*k +: 8];
        end
      end else begin
        bresp_d = RespOor;
      end
    end
  end

  // Write path and register bank flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q <= WIdle;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RespOkay;
      pulse_q  <= '0;
      for (int i = 0; i < REGISTER_COUNT; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < REGISTER_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read FSM: sample the pre-edge register value on AR, hold it until rready.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    unique case (rstate_q)
      RIdle: begin
        if (ar_hs) begin
          rstate_d = RResp;
          if (ar_in_range) begin
            rdata_d = regs_q[ar_idx];
            rresp_d = RespOkay;
          end else begin
            rdata_d = '0;
            rresp_d = RespOor;
          end
        end
      end
      RResp: begin
        if (s_axi_rready) rstate_d = RIdle;
      end
      default: rstate_d = RIdle;
    endcase
  end

  // Read path flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= RIdle;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axi_bvalid         = (wstate_q == WResp);
  assign s_axi_bresp          = bresp_q;
  assign s_axi_rvalid         = (rstate_q == RResp);
  assign s_axi_rdata          = rdata_q;
  assign s_axi_rresp          = rresp_q;
  assign register_write_pulse = pulse_q;

  for (genvar g = 0; g < REGISTER_COUNT; g++) begin : g_flatten
    assign register_file[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed steps followed by random traffic
// checked against an array model of the register bank.
module tb_axi4_lite_slave_regs;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned RC   = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef AXI4_LITE_SLAVE_OOR_ERROR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic [AW-1:0]    s_axi_awaddr;
  logic             s_axi_awvalid;
  logic             s_axi_awready;
  logic [DW-1:0]    s_axi_wdata;
  logic [DW/8-1:0]  s_axi_wstrb;
  logic             s_axi_wvalid;
  logic             s_axi_wready;
  logic [1:0]       s_axi_bresp;
  logic             s_axi_bvalid;
  logic             s_axi_bready;
  logic [AW-1:0]    s_axi_araddr;
  logic             s_axi_arvalid;
  logic             s_axi_arready;
  logic [DW-1:0]    s_axi_rdata;
  logic [1:0]       s_axi_rresp;
  logic             s_axi_rvalid;
  logic             s_axi_rready;
  logic [RC*DW-1:0] register_file;
  logic [RC-1:0]    register_write_pulse;

  axi4_lite_slave_regs #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .BASE_ADDRESS   (BASE),
    .REGISTER_COUNT (RC)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .s_axi_awaddr         (s_axi_awaddr),
    .s_axi_awvalid        (s_axi_awvalid),
    .s_axi_awready        (s_axi_awready),
    .s_axi_wdata          (s_axi_wdata),
    .s_axi_wstrb          (s_axi_wstrb),
    .s_axi_wvalid         (s_axi_wvalid),
    .s_axi_wready         (s_axi_wready),
    .s_axi_bresp          (s_axi_bresp),
    .s_axi_bvalid         (s_axi_bvalid),
    .s_axi_bready         (s_axi_bready),
    .s_axi_araddr         (s_axi_araddr),
    .s_axi_arvalid        (s_axi_arvalid),
    .s_axi_arready        (s_axi_arready),
    .s_axi_rdata          (s_axi_rdata),
    .s_axi_rresp          (s_axi_rresp),
    .s_axi_rvalid         (s_axi_rvalid),
    .s_axi_rready         (s_axi_rready),
    .register_file        (register_file),
    .register_write_pulse (register_write_pulse)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: one word per register.
  logic [31:0] model [RC];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < RC; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(RC * 4));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RC; i++) model[i] = '0;
  endtask

  // Full write transaction with independent AW/W start delays and a bready hold.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input string tag);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    logic [7:0] exp_pulse;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; c = 0;
    @(posedge clk); #1;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && c < 64) begin
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wvalid  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (w_done && !aw_done) check({tag, ".wready_wait"}, s_axi_wready, 1'b0);
      if (aw_done && !w_done) check({tag, ".awready_wait"}, s_axi_awready, 1'b0);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      c++;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    if (!(aw_done && w_done)) begin
      check({tag, ".hs_timeout"}, {aw_done, w_done}, 2'b11);
      return;
    end
    if (in_rng(addr)) begin
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx_of(addr)][8*k +: 8] = data[8*k +: 8];
      exp_pulse = 8'(1 << idx_of(addr));
      exp_resp  = 2'b00;
    end else begin
      exp_pulse = '0;
      exp_resp  = OOR_RESP;
    end
    @(negedge clk);
    check({tag, ".bvalid"}, s_axi_bvalid, 1'b1);
    check({tag, ".bresp"}, s_axi_bresp, exp_resp);
    check({tag, ".pulse"}, register_write_pulse, exp_pulse);
    check({tag, ".regfile"}, register_file, model_vec());
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".bhold"}, {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready},
            {1'b1, exp_resp, 2'b00});
      check({tag, ".pulse_once"}, register_write_pulse, 8'h00);
    end
    s_axi_bready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0;
    @(negedge clk);
    check({tag, ".bdone"}, s_axi_bvalid, 1'b0);
  endtask

  // Full read transaction; rready is withheld for r_dly cycles.
  task automatic do_read(input logic [31:0] addr, input int r_dly, input string tag);
    bit hs;
    int c;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    hs = 0; c = 0;
    @(posedge clk); #1;
    exp_data = in_rng(addr) ? model[idx_of(addr)] : 32'h0;
    exp_resp = in_rng(addr) ? 2'b00 : OOR_RESP;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1;
    while (!hs && c < 16) begin
      @(negedge clk);
      hs = s_axi_arready;
      @(posedge clk); #1;
      c++;
    end
    s_axi_arvalid = 0;
    check({tag, ".ar_hs"}, hs, 1'b1);
    @(negedge clk);
    check({tag, ".r"}, {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, exp_resp, exp_data});
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".rhold"}, {s_axi_rvalid, s_axi_rresp, s_axi_rdata, s_axi_arready},
            {1'b1, exp_resp, exp_data, 1'b0});
    end
    s_axi_rready = 1;
    @(posedge clk); #1;
    s_axi_rready = 0;
    @(negedge clk);
    check({tag, ".rdone"}, s_axi_rvalid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".readys"}, {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check({tag, ".resp"}, {s_axi_bvalid, s_axi_bresp, s_axi_rvalid, s_axi_rresp}, 6'b0);
    check({tag, ".rdata"}, s_axi_rdata, 32'h0);
    check({tag, ".pulse"}, register_write_pulse, 8'h00);
    check({tag, ".regfile"}, register_file, 256'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old;
    int r;
    resetn = 0;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
    s_axi_rready = 0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1;

    // AW+W same cycle, full strobe
    do_write(BASE, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, "w_full");
    // Partial strobe and readback
    do_write(BASE, 32'h0000_1234, 4'b0011, 0, 0, 1, "w_partial");
    do_read(BASE, 0, "r_partial");
    check("partial_value", register_file[31:0], 32'hFFFF_1234);
    // W first, AW three cycles later, bready withheld four cycles
    do_write(BASE + 32'h0C, 32'hA5A5_0000, 4'b1111, 3, 0, 4, "w_split");
    // AW first, W later
    do_write(BASE + 32'h08, 32'h1357_9BDF, 4'b1010, 0, 2, 0, "w_split_aw");
    // Zero strobe still commits and pulses
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0, "w_nostrb");

    // Read on the commit edge of a write to the same register sees the old value
    @(posedge clk); #1;
    old = model[1];
    s_axi_awaddr = BASE + 4; s_axi_wdata = 32'h0000_FFFF; s_axi_wstrb = 4'hF;
    s_axi_araddr = BASE + 4;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(negedge clk);
    check("same_edge.readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    model[1] = 32'h0000_FFFF;
    @(negedge clk);
    check("same_edge.r", {s_axi_rvalid, s_axi_rdata}, {1'b1, old});
    check("same_edge.b", {s_axi_bvalid, register_write_pulse}, {1'b1, 8'h02});
    s_axi_bready = 1; s_axi_rready = 1;
    @(posedge clk); #1;
    s_axi_bready = 0; s_axi_rready = 0;
    do_read(BASE + 4, 2, "r_after_same");

    // Out of range, one word past the bank
    do_write(BASE + 32'h20, 32'h5555_AAAA, 4'hF, 0, 0, 0, "w_oor");
    do_read(BASE + 32'h20, 0, "r_oor");
    do_read(BASE + 32'h0E, 0, "r_unaligned");

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'h20 + 32'($urandom_range(0, 63));
      else a = BASE - 32'($urandom_range(1, 16));
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd_w");
      else
        do_read(a, int'($urandom_range(0, 2)), "rnd_r");
    end

    // Reset while a write response is pending
    @(posedge clk); #1;
    s_axi_awaddr = BASE + 8; s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge clk);
    check("rst_b.pending", s_axi_bvalid, 1'b1);
    resetn = 0;
    model_reset();
    #1;
    check_reset_outputs("rst_b");
    @(negedge clk);
    resetn = 1;
    repeat (2) begin
      @(negedge clk);
      check("rst_b.no_stale", {s_axi_bvalid, register_file}, {1'b0, model_vec()});
    end

    // Reset while an address is held without data; the later W must not complete it
    @(posedge clk); #1;
    s_axi_awaddr = BASE + 8; s_axi_awvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    @(negedge clk);
    check("rst_aw.held", {s_axi_awready, s_axi_wready}, 2'b01);
    resetn = 0;
    #1;
    check_reset_outputs("rst_aw");
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
    s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_aw.no_commit", {s_axi_bvalid, register_write_pulse, register_file},
            {1'b0, 8'h00, model_vec()});
    end
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    do_write(BASE + 32'h1C, 32'h0BAD_F00D, 4'hF, 1, 0, 0, "w_post_rst");
    do_read(BASE + 32'h1C, 0, "r_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
